// File: rtl/iic_pkg.sv
// Shared definitions for the IIC init sequencer: table entry layout, delay marker and FSM encoding.
// Readback states exist only when IIC_INIT_READBACK_EN is defined.
package iic_pkg;

    localparam int          ENTRY_W    = 21;
    localparam logic [12:0] DELAY_MARK = 13'h1FFF;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        LOAD     = 4'd2,
        ISSUE_WR = 4'd3,
        WAIT_WR  = 4'd4,
`ifdef IIC_INIT_READBACK_EN
        ISSUE_RD = 4'd5,
        WAIT_RD  = 4'd6,
        CHECK    = 4'd7,
`endif
        DELAY    = 4'd8,
        NEXT     = 4'd9,
        FIN      = 4'd10,
        FAIL     = 4'd11
    } state_t;

    function automatic logic [12:0] entry_reg(input logic [ENTRY_W-1:0] e);
        return e[20:8];
    endfunction

    function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
        return e[7:0];
    endfunction

endpackage

// File: rtl/iic_init_rom.sv
// Init table storage: 256 x 21-bit entries, synchronous read with one-cycle latency.
// The image is written through the prog port before the sequencer is started.
module iic_init_rom
    import iic_pkg::*;
(
    input  logic        clk,
    input  logic        prog_en,
    input  logic [7:0]  prog_addr,
    input  logic [20:0] prog_data,
    input  logic [7:0]  addr,
    output logic [20:0] data
);

    logic [ENTRY_W-1:0] mem [256];

    always_ff @(posedge clk) begin
        if (prog_en) begin
            mem[prog_addr] <= prog_data;
        end
        data <= mem[addr];
    end

endmodule

// File: rtl/iic_init_seq.sv
// Walks an init table and issues one IIC write per entry, with delay entries, timeout and retry.
// Define IIC_INIT_READBACK_EN to read each register back and verify it after the write.
module iic_init_seq
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         TBL_LEN    = 64,
    parameter logic [1:0] REG_LEN    = 2'd2,
    parameter int         TIMEOUT    = 200000,
    parameter int         MAX_RETRY  = 2,
    parameter int         DELAY_UNIT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        init_done,
    output logic        err,
    output logic [7:0]  err_index,
    output logic [7:0]  tbl_addr,
    input  logic [20:0] tbl_data,
    output logic        wr_en,
    output logic        re_en,
    output logic [6:0]  addr_se_me,
    output logic [12:0] addr_se_reg,
    output logic [1:0]  num_reg_add,
    output logic [7:0]  num_sent_data,
    output logic [7:0]  num_rece_data,
    output logic [7:0]  sda_data_out,
    input  logic        done,
    input  logic [7:0]  data_out
);

    localparam logic [17:0] TO_MAX    = 18'(TIMEOUT);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [7:0]  LAST_IDX  = 8'(TBL_LEN - 1);
    localparam logic [23:0] DLY_UNIT  = 24'(DELAY_UNIT);

    state_t      state_reg, state_next;
    logic [7:0]  index_reg;
    logic [7:0]  retry_reg;
    logic [17:0] to_cnt_reg;
    logic [23:0] dly_cnt_reg;
    logic [12:0] reg_addr_reg;
    logic [7:0]  wdata_reg;
    logic        err_reg;
    logic [7:0]  err_index_reg;

    logic timed_out, retry_ok, last_entry, is_delay;

`ifdef IIC_INIT_READBACK_EN
    logic [7:0] rd_data_reg;
    logic       rd_match;
    assign rd_match = (rd_data_reg == wdata_reg);
`else
    logic unused_rd;
    assign unused_rd = ^data_out;
`endif

    assign timed_out  = (to_cnt_reg == TO_MAX);
    assign retry_ok   = (retry_reg < RETRY_MAX);
    assign last_entry = (index_reg == LAST_IDX);
    assign is_delay   = (entry_reg(tbl_data) == DELAY_MARK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = FETCH;
            FETCH:    state_next = LOAD;
            LOAD:     state_next = is_delay ? DELAY : ISSUE_WR;
            DELAY:    if (dly_cnt_reg == 24'd0) state_next = NEXT;
            ISSUE_WR: state_next = WAIT_WR;
            WAIT_WR: begin
                if (done) begin
`ifdef IIC_INIT_READBACK_EN
                    state_next = ISSUE_RD;
`else
                    state_next = NEXT;
`endif
                end else if (timed_out) begin
                    state_next = retry_ok ? ISSUE_WR : FAIL;
                end
            end
`ifdef IIC_INIT_READBACK_EN
            ISSUE_RD: state_next = WAIT_RD;
            WAIT_RD: begin
                if (done) begin
                    state_next = CHECK;
                end else if (timed_out) begin
                    state_next = retry_ok ? ISSUE_RD : FAIL;
                end
            end
            CHECK: begin
                if (rd_match) state_next = NEXT;
                else          state_next = retry_ok ? ISSUE_WR : FAIL;
            end
`endif
            NEXT:     state_next = last_entry ? FIN : FETCH;
            FIN:      state_next = IDLE;
            FAIL:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_reg     <= '0;
            retry_reg     <= '0;
            to_cnt_reg    <= '0;
            dly_cnt_reg   <= '0;
            reg_addr_reg  <= '0;
            wdata_reg     <= '0;
            err_reg       <= 1'b0;
            err_index_reg <= '0;
`ifdef IIC_INIT_READBACK_EN
            rd_data_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        index_reg <= '0;
                        retry_reg <= '0;
                        err_reg   <= 1'b0;
                    end
                end
                LOAD: begin
                    reg_addr_reg <= entry_reg(tbl_data);
                    wdata_reg    <= entry_data(tbl_data);
                    dly_cnt_reg  <= 24'(entry_data(tbl_data)) * DLY_UNIT;
                end
                DELAY: begin
                    if (dly_cnt_reg != 24'd0) dly_cnt_reg <= dly_cnt_reg - 24'd1;
                end
                ISSUE_WR: to_cnt_reg <= '0;
                WAIT_WR: begin
                    if (!timed_out) to_cnt_reg <= to_cnt_reg + 18'd1;
                    if (!done && timed_out && retry_ok) retry_reg <= retry_reg + 8'd1;
                end
`ifdef IIC_INIT_READBACK_EN
                ISSUE_RD: to_cnt_reg <= '0;
                WAIT_RD: begin
                    if (!timed_out) to_cnt_reg <= to_cnt_reg + 18'd1;
                    if (done) rd_data_reg <= data_out;
                    else if (timed_out && retry_ok) retry_reg <= retry_reg + 8'd1;
                end
                CHECK: begin
                    if (!rd_match && retry_ok) retry_reg <= retry_reg + 8'd1;
                end
`endif
                NEXT: begin
                    retry_reg <= '0;
                    if (!last_entry) index_reg <= index_reg + 8'd1;
                end
                FAIL: begin
                    err_reg       <= 1'b1;
                    err_index_reg <= index_reg;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state so reset kills them on the very next cycle.
    assign wr_en         = (state_reg == ISSUE_WR);
`ifdef IIC_INIT_READBACK_EN
    assign re_en         = (state_reg == ISSUE_RD);
`else
    assign re_en         = 1'b0;
`endif
    assign busy          = (state_reg != IDLE);
    assign init_done     = (state_reg == FIN);
    assign err           = err_reg;
    assign err_index     = err_index_reg;
    assign tbl_addr      = index_reg;
    assign addr_se_me    = DEV_ADDR;
    assign addr_se_reg   = reg_addr_reg;
    assign num_reg_add   = REG_LEN;
    assign num_sent_data = 8'd1;
    assign num_rece_data = 8'd1;
    assign sda_data_out  = wdata_reg;

endmodule

// File: tb/tb_iic_init_seq.sv
// Bench for iic_init_seq: table image in iic_init_rom, behavioural IIC controller responder,
// directed scenarios plus randomized tables checked against a table-walk reference model.
module tb_iic_init_seq;

    localparam int TBL_LEN    = 3;
    localparam int TIMEOUT    = 500;
    localparam int MAX_RETRY  = 2;
    localparam int DELAY_UNIT = 10;
`ifdef IIC_INIT_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, done;
    logic [7:0]  data_out;
    logic        busy, init_done, err, wr_en, re_en;
    logic [7:0]  err_index, tbl_addr, num_sent_data, num_rece_data, sda_data_out;
    logic [20:0] tbl_data;
    logic [6:0]  addr_se_me;
    logic [12:0] addr_se_reg;
    logic [1:0]  num_reg_add;
    logic        prog_en;
    logic [7:0]  prog_addr;
    logic [20:0] prog_data;

    always #5 clk = ~clk;

    iic_init_seq #(
        .DEV_ADDR(7'h3C), .TBL_LEN(TBL_LEN), .REG_LEN(2'd2), .TIMEOUT(TIMEOUT),
        .MAX_RETRY(MAX_RETRY), .DELAY_UNIT(DELAY_UNIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .init_done(init_done),
        .err(err), .err_index(err_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .wr_en(wr_en), .re_en(re_en), .addr_se_me(addr_se_me), .addr_se_reg(addr_se_reg),
        .num_reg_add(num_reg_add), .num_sent_data(num_sent_data),
        .num_rece_data(num_rece_data), .sda_data_out(sda_data_out),
        .done(done), .data_out(data_out)
    );

    iic_init_rom rom (
        .clk(clk), .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
        .addr(tbl_addr), .data(tbl_data)
    );

    int cmp_cnt = 0;
    int mis_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [20:0] tbl [TBL_LEN];
    logic [20:0] wr_log [$];
    int          wr_cyc [$];
    int          rd_cnt = 0, init_cnt = 0, overlap_cnt = 0;

    // Responder configuration (written only by the main sequence)
    int          resp_lat = 10;
    bit          drop_en = 1'b0;
    logic [12:0] drop_reg = '0;
    int          rb_bad_until = 0;
    int          rd_served = 0;

    // Reference model output
    logic [20:0] exp_w [$];
    int          exp_g [$];
    bit          exp_fail;
    int          exp_idx;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (wr_en) begin
                wr_log.push_back({addr_se_reg, sda_data_out});
                wr_cyc.push_back(cyc);
                $display("wr  cyc=%0d reg=%h data=%h", cyc, addr_se_reg, sda_data_out);
            end
            if (re_en) rd_cnt++;
            if (init_done) init_cnt++;
            if (wr_en && re_en) overlap_cnt++;
        end
    end

    // Controller model: answers each request after resp_lat cycles unless the register is dropped.
    initial begin : responder
        bit pend, ack, is_rd;
        int cnt;
        logic [7:0] last_wr;
        pend = 0; ack = 0; is_rd = 0; cnt = 0; last_wr = '0;
        done = 1'b0; data_out = '0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (wr_en || re_en) begin
                pend  = 1;
                cnt   = resp_lat;
                is_rd = re_en;
                ack   = !(drop_en && addr_se_reg == drop_reg);
                if (wr_en) last_wr = sda_data_out;
            end else if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    pend = 0;
                    if (ack) begin
                        done = 1'b1;
                        if (is_rd) begin
                            data_out = (rd_served < rb_bad_until) ? 8'hAA : last_wr;
                            rd_served++;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_table();
        for (int i = 0; i < TBL_LEN; i++) begin
            @(negedge clk);
            prog_en = 1'b1; prog_addr = 8'(i); prog_data = tbl[i];
        end
        @(negedge clk);
        prog_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done || (err && !busy)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected write sequence: one write per register entry, delay entries add minimum spacing,
    // a silent register burns MAX_RETRY+1 writes and fails, a bad readback costs one extra write.
    task automatic model_run(input int bad_reads);
        int gap, bad, tries;
        logic [12:0] r;
        logic [7:0]  d;
        exp_w.delete(); exp_g.delete();
        exp_fail = 1'b0; exp_idx = 0; gap = 0; bad = bad_reads;
        for (int i = 0; i < TBL_LEN; i++) begin
            r = tbl[i][20:8];
            d = tbl[i][7:0];
            if (r == 13'h1FFF) begin
                gap += int'(d) * DELAY_UNIT;
                continue;
            end
            if (drop_en && r == drop_reg) begin
                for (int k = 0; k <= MAX_RETRY; k++) begin
                    exp_w.push_back(tbl[i]);
                    exp_g.push_back(k == 0 ? gap : 0);
                end
                exp_fail = 1'b1; exp_idx = i;
                return;
            end
            tries = 0;
            forever begin
                exp_w.push_back(tbl[i]);
                exp_g.push_back(tries == 0 ? gap : 0);
                if (READBACK && bad > 0) begin
                    bad--; tries++;
                    if (tries > MAX_RETRY) begin
                        exp_fail = 1'b1; exp_idx = i;
                        return;
                    end
                end else begin
                    break;
                end
            end
            gap = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if ({busy, init_done, err, wr_en, re_en} !== 5'b0) begin
            mis_cnt++; $display("FAIL reset_ctrl: got %b want 00000", {busy, init_done, err, wr_en, re_en});
        end
        cmp_cnt++;
        if (err_index !== 8'd0) begin
            mis_cnt++; $display("FAIL reset_err_index: got %h want 00", err_index);
        end
        cmp_cnt++;
        if (tbl_addr !== 8'd0) begin
            mis_cnt++; $display("FAIL reset_tbl_addr: got %h want 00", tbl_addr);
        end
        cmp_cnt++;
        if ({addr_se_reg, sda_data_out} !== 21'd0) begin
            mis_cnt++; $display("FAIL reset_wr_regs: got %h want 0", {addr_se_reg, sda_data_out});
        end
        cmp_cnt++;
        if ({addr_se_me, num_reg_add, num_sent_data, num_rece_data} !== {7'h3C, 2'd2, 8'd1, 8'd1}) begin
            mis_cnt++; $display("FAIL const_outputs: got %h/%h/%h/%h want 3c/2/01/01",
                                addr_se_me, num_reg_add, num_sent_data, num_rece_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int wb, ib;
        bit ok;
        tbl[0] = {13'h0010, 8'h11}; tbl[1] = {13'h0123, 8'h22}; tbl[2] = {13'h1ABC, 8'h33};
        resp_lat = 400; drop_en = 1'b0;
        load_table();
        wb = wr_log.size(); ib = init_cnt;
        pulse_start();
        cmp_cnt++;
        if (busy !== 1'b1) begin
            mis_cnt++; $display("FAIL basic_busy_start: got %b want 1", busy);
        end
        wait_end(5000, ok);
        cmp_cnt++;
        if (!ok || init_done !== 1'b1) begin
            mis_cnt++; $display("FAIL basic_finish: got ok=%b init_done=%b want 1/1", ok, init_done);
        end
        @(negedge clk);
        cmp_cnt++;
        if ({busy, init_done} !== 2'b00) begin
            mis_cnt++; $display("FAIL basic_after_done: got busy/init_done=%b want 00", {busy, init_done});
        end
        cmp_cnt++;
        if (wr_log.size() - wb !== 3) begin
            mis_cnt++; $display("FAIL basic_wr_count: got %0d want 3", wr_log.size() - wb);
        end
        for (int k = 0; k < 3 && wb + k < wr_log.size(); k++) begin
            cmp_cnt++;
            if (wr_log[wb + k] !== tbl[k]) begin
                mis_cnt++; $display("FAIL basic_wr%0d: got %h want %h", k, wr_log[wb + k], tbl[k]);
            end
        end
        cmp_cnt++;
        if (init_cnt - ib !== 1 || err !== 1'b0) begin
            mis_cnt++; $display("FAIL basic_status: got init_pulses=%0d err=%b want 1/0", init_cnt - ib, err);
        end
    endtask

    task automatic test_delay();
        int wb;
        bit ok;
        tbl[0] = {13'h0020, 8'h5A}; tbl[1] = {13'h1FFF, 8'd2}; tbl[2] = {13'h0030, 8'hA5};
        resp_lat = 5; drop_en = 1'b0;
        load_table();
        wb = wr_log.size();
        pulse_start();
        wait_end(2000, ok);
        @(negedge clk);
        cmp_cnt++;
        if (!ok || wr_log.size() - wb !== 2) begin
            mis_cnt++; $display("FAIL delay_wr_count: got ok=%b count=%0d want 1/2", ok, wr_log.size() - wb);
        end else begin
            cmp_cnt++;
            if (wr_log[wb] !== tbl[0] || wr_log[wb + 1] !== tbl[2]) begin
                mis_cnt++; $display("FAIL delay_wr_data: got %h,%h want %h,%h", wr_log[wb], wr_log[wb + 1], tbl[0], tbl[2]);
            end
            cmp_cnt++;
            if (wr_cyc[wb + 1] - wr_cyc[wb] < 20) begin
                mis_cnt++; $display("FAIL delay_gap: got %0d cycles want >= 20", wr_cyc[wb + 1] - wr_cyc[wb]);
            end
        end
    endtask

    task automatic test_timeout();
        int wb, ib;
        bit ok;
        logic [20:0] want [4];
        tbl[0] = {13'h0040, 8'h01}; tbl[1] = {13'h0041, 8'h02}; tbl[2] = {13'h0042, 8'h03};
        want[0] = tbl[0]; want[1] = tbl[1]; want[2] = tbl[1]; want[3] = tbl[1];
        resp_lat = 10; drop_en = 1'b1; drop_reg = 13'h0041;
        load_table();
        wb = wr_log.size(); ib = init_cnt;
        pulse_start();
        wait_end(5000, ok);
        @(negedge clk);
        cmp_cnt++;
        if (!ok || {err, busy} !== 2'b10) begin
            mis_cnt++; $display("FAIL timeout_err: got ok=%b err=%b busy=%b want 1/1/0", ok, err, busy);
        end
        cmp_cnt++;
        if (err_index !== 8'd1) begin
            mis_cnt++; $display("FAIL timeout_err_index: got %0d want 1", err_index);
        end
        cmp_cnt++;
        if (init_cnt - ib !== 0) begin
            mis_cnt++; $display("FAIL timeout_no_done: got %0d init_done pulses want 0", init_cnt - ib);
        end
        cmp_cnt++;
        if (wr_log.size() - wb !== 4) begin
            mis_cnt++; $display("FAIL timeout_wr_count: got %0d want 4", wr_log.size() - wb);
        end
        for (int k = 0; k < 4 && wb + k < wr_log.size(); k++) begin
            cmp_cnt++;
            if (wr_log[wb + k] !== want[k]) begin
                mis_cnt++; $display("FAIL timeout_wr%0d: got %h want %h", k, wr_log[wb + k], want[k]);
            end
        end
        drop_en = 1'b0;
    endtask

`ifdef IIC_INIT_READBACK_EN
    task automatic test_readback();
        int wb, rb, ib;
        bit ok;
        logic [20:0] want [4];
        tbl[0] = {13'h0050, 8'h55}; tbl[1] = {13'h0051, 8'h66}; tbl[2] = {13'h0052, 8'h77};
        want[0] = tbl[0]; want[1] = tbl[0]; want[2] = tbl[1]; want[3] = tbl[2];
        resp_lat = 8; drop_en = 1'b0;
        load_table();
        wb = wr_log.size(); rb = rd_cnt; ib = init_cnt;
        rb_bad_until = rd_served + 1;
        pulse_start();
        wait_end(5000, ok);
        @(negedge clk);
        cmp_cnt++;
        if (!ok || err !== 1'b0 || init_cnt - ib !== 1) begin
            mis_cnt++; $display("FAIL readback_finish: got ok=%b err=%b pulses=%0d want 1/0/1", ok, err, init_cnt - ib);
        end
        cmp_cnt++;
        if (wr_log.size() - wb !== 4 || rd_cnt - rb !== 4) begin
            mis_cnt++; $display("FAIL readback_counts: got wr=%0d rd=%0d want 4/4", wr_log.size() - wb, rd_cnt - rb);
        end
        for (int k = 0; k < 4 && wb + k < wr_log.size(); k++) begin
            cmp_cnt++;
            if (wr_log[wb + k] !== want[k]) begin
                mis_cnt++; $display("FAIL readback_wr%0d: got %h want %h", k, wr_log[wb + k], want[k]);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int wb, wb2;
        bit ok;
        tbl[0] = {13'h0060, 8'hC1}; tbl[1] = {13'h0061, 8'hC2}; tbl[2] = {13'h0062, 8'hC3};
        resp_lat = 100; drop_en = 1'b0;
        load_table();
        wb = wr_log.size();
        pulse_start();
        for (int i = 0; i < 300 && wr_log.size() <= wb; i++) @(negedge clk);
        cmp_cnt++;
        if (wr_log.size() <= wb) begin
            mis_cnt++; $display("FAIL reset_mid_first_wr: got no write want one");
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if ({busy, wr_en} !== 2'b00) begin
            mis_cnt++; $display("FAIL reset_mid_idle: got busy/wr_en=%b want 00", {busy, wr_en});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wb2 = wr_log.size();
        repeat (150) @(negedge clk);
        cmp_cnt++;
        if (wr_log.size() !== wb2 || busy !== 1'b0) begin
            mis_cnt++; $display("FAIL reset_mid_quiet: got writes=%0d busy=%b want 0/0", wr_log.size() - wb2, busy);
        end
        resp_lat = 5;
        pulse_start();
        wait_end(2000, ok);
        @(negedge clk);
        cmp_cnt++;
        if (!ok || wr_log.size() - wb2 !== 3) begin
            mis_cnt++; $display("FAIL reset_mid_rerun: got ok=%b writes=%0d want 1/3", ok, wr_log.size() - wb2);
        end else begin
            cmp_cnt++;
            if (wr_log[wb2] !== tbl[0]) begin
                mis_cnt++; $display("FAIL reset_mid_from0: got %h want %h", wr_log[wb2], tbl[0]);
            end
        end
    endtask

    task automatic test_start_busy();
        int wb, ib;
        bit ok;
        logic [7:0] ta;
        tbl[0] = {13'h0070, 8'hD1}; tbl[1] = {13'h0071, 8'hD2}; tbl[2] = {13'h0072, 8'hD3};
        resp_lat = 60; drop_en = 1'b0;
        load_table();
        wb = wr_log.size(); ib = init_cnt;
        pulse_start();
        for (int i = 0; i < 500 && wr_log.size() < wb + 2; i++) @(negedge clk);
        ta = tbl_addr;
        pulse_start();
        cmp_cnt++;
        if (tbl_addr !== 8'd1 || ta !== 8'd1) begin
            mis_cnt++; $display("FAIL start_busy_index: got before=%0d after=%0d want 1/1", ta, tbl_addr);
        end
        wait_end(3000, ok);
        @(negedge clk);
        cmp_cnt++;
        if (!ok || wr_log.size() - wb !== 3 || init_cnt - ib !== 1) begin
            mis_cnt++; $display("FAIL start_busy_run: got ok=%b writes=%0d pulses=%0d want 1/3/1",
                                ok, wr_log.size() - wb, init_cnt - ib);
        end
        for (int k = 0; k < 3 && wb + k < wr_log.size(); k++) begin
            cmp_cnt++;
            if (wr_log[wb + k] !== tbl[k]) begin
                mis_cnt++; $display("FAIL start_busy_wr%0d: got %h want %h", k, wr_log[wb + k], tbl[k]);
            end
        end
    endtask

    task automatic test_random();
        int wb, ib, sc, prev, bad_reads;
        bit ok;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < TBL_LEN; i++) begin
                if ($urandom_range(0, 3) == 0) tbl[i] = {13'h1FFF, 8'($urandom_range(0, 4))};
                else                           tbl[i] = {13'($urandom_range(0, 13'h1FFE)), 8'($urandom)};
            end
            drop_en   = ($urandom_range(0, 3) == 0);
            drop_reg  = tbl[$urandom_range(0, TBL_LEN - 1)][20:8];
            resp_lat  = int'($urandom_range(1, 60));
            bad_reads = READBACK ? int'($urandom_range(0, 1)) : 0;
            model_run(bad_reads);
            load_table();
            wb = wr_log.size(); ib = init_cnt;
            rb_bad_until = rd_served + bad_reads;
            sc = cyc;
            pulse_start();
            wait_end(8000, ok);
            @(negedge clk);
            cmp_cnt++;
            if (!ok || wr_log.size() - wb !== exp_w.size()) begin
                mis_cnt++; $display("FAIL rand%0d_wr_count: got ok=%b count=%0d want 1/%0d",
                                    it, ok, wr_log.size() - wb, exp_w.size());
            end
            prev = sc;
            for (int k = 0; k < exp_w.size() && wb + k < wr_log.size(); k++) begin
                cmp_cnt++;
                if (wr_log[wb + k] !== exp_w[k] || wr_cyc[wb + k] - prev < exp_g[k]) begin
                    mis_cnt++; $display("FAIL rand%0d_wr%0d: got %h gap=%0d want %h gap>=%0d",
                                        it, k, wr_log[wb + k], wr_cyc[wb + k] - prev, exp_w[k], exp_g[k]);
                end
                prev = wr_cyc[wb + k];
            end
            cmp_cnt++;
            if (err !== exp_fail || init_cnt - ib !== (exp_fail ? 0 : 1)) begin
                mis_cnt++; $display("FAIL rand%0d_status: got err=%b pulses=%0d want err=%b", it, err, init_cnt - ib, exp_fail);
            end
            if (exp_fail) begin
                cmp_cnt++;
                if (err_index !== 8'(exp_idx)) begin
                    mis_cnt++; $display("FAIL rand%0d_err_index: got %0d want %0d", it, err_index, exp_idx);
                end
            end
        end
        drop_en = 1'b0;
    endtask

    initial begin : main
        rst = 1'b1; start = 1'b0;
        prog_en = 1'b0; prog_addr = '0; prog_data = '0;
        test_reset();
        test_basic();
        test_delay();
        test_timeout();
`ifdef IIC_INIT_READBACK_EN
        test_readback();
`endif
        test_reset_mid();
        test_start_busy();
        test_random();
        cmp_cnt++;
        if (overlap_cnt !== 0) begin
            mis_cnt++; $display("FAIL wr_re_overlap: got %0d cycles want 0", overlap_cnt);
        end
`ifndef IIC_INIT_READBACK_EN
        cmp_cnt++;
        if (rd_cnt !== 0) begin
            mis_cnt++; $display("FAIL re_en_tied: got %0d pulses want 0", rd_cnt);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
